alu_req_arbiter: RTL and testbench

- Shares one calculator ALU (ops: add, sub, and, or, mul, div) among NUM_REQ requesters, e.g. several keypad/control FSMs.
- Arbitrates requests round-robin, latches the winner's operands and issues a single-cycle start to the ALU.
- Waits for ALU completion or a watchdog timeout, then returns a tagged response.
- Sits between the control FSMs and the shared ALU datapath.

---
 rtl/alu_req_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one calculator ALU among NUM_REQ requesters.
// Latency: ack and alu_start one cycle after grant; response 2 + ALU latency cycles after ack (watchdog capped).
// Backpressure: requesters hold req/operands until ack; no new grant is taken until the response returns to IDLE.
module alu_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]      req_op,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      alu_start,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [2:0]                alu_op,
  input  logic                      alu_done,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_result,
  output logic                      resp_err,
  output logic                      busy
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     winner;
  logic [NUM_REQ-1:0]  grant_vec;
  logic                found;
  logic                any_req;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [2:0]          sel_op;
  logic [CNT_W-1:0]    wait_cnt;
  logic                timeout_hit;
  logic                err_q;

  assign any_req     = |req;
  assign timeout_hit = (wait_cnt == CNT_LAST);

  // Round-robin pick: first requester above last_grant, else wrap to the lowest at or below it.
  always_comb begin
    winner    = '0;
    grant_vec = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (ID_W'(i) > last_grant)) begin
        winner       = ID_W'(i);
        grant_vec    = '0;
        grant_vec[i] = 1'b1;
        found        = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (ID_W'(i) <= last_grant)) begin
        winner       = ID_W'(i);
        grant_vec    = '0;
        grant_vec[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  // Operand mux selecting the winner's slices.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_a  = req_a[i*DATA_W +: DATA_W];
        sel_b  = req_b[i*DATA_W +: DATA_W];
        sel_op = req_op[i*3 +: 3];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: done has priority over the watchdog in WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (alu_done || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; the error flag is only visible with the response strobe.
  always_comb begin
    alu_start  = (state == ISSUE);
    busy       = (state != IDLE);
    resp_valid = (state == RESP);
    resp_err   = (state == RESP) && err_q;
  end

  // Datapath: grant/operand latch, watchdog counter and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant  <= LAST_INIT;
      ack         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      resp_id     <= '0;
      resp_result <= '0;
      err_q       <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            ack        <= grant_vec;
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            alu_op     <= sel_op;
            resp_id    <= winner;
            last_grant <= winner;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
        end
        WAIT: begin
          if (alu_done) begin
            resp_result <= alu_result;
            err_q       <= 1'b0;
          end else if (timeout_hit) begin
            resp_result <= '1;
            err_q       <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: table-driven single transactions, round-robin sequences,
// watchdog/done races, stray done and mid-transaction reset, with a response scoreboard.
module tb_alu_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*3-1:0]      req_op;
  logic [NUM_REQ-1:0]        ack;
  logic                      alu_start;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [2:0]                alu_op;
  logic                      alu_done;
  logic [DATA_W-1:0]         alu_result;
  logic                      resp_valid;
  logic [ID_W-1:0]           resp_id;
  logic [DATA_W-1:0]         resp_result;
  logic                      resp_err;
  logic                      busy;

  alu_req_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .ack(ack), .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_done(alu_done), .alu_result(alu_result), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_result(resp_result), .resp_err(resp_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    int         lat;   // cycles from WAIT entry to done; 0 = never
    logic [7:0] res;
    logic       err;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] res;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;
  int   alu_lat;
  int   stray_req;
  int   stray_ack;
  int   rr_ids[5];
  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return p[7:0];
      3'd5:    return (b == 8'd0) ? 8'hFF : a / b;
      default: return 8'h00;
    endcase
  endfunction

  // ALU model and response scoreboard.
  initial begin
    logic       pending;
    int         wcnt;
    logic [7:0] res;
    logic [18:0] held;
    exp_t       e;
    alu_done   = 1'b0;
    alu_result = '0;
    pending    = 1'b0;
    wcnt       = 0;
    res        = '0;
    held       = '0;
    stray_ack  = 0;
    forever begin
      step();
      alu_done = 1'b0;
      if (rst || !busy) pending = 1'b0;
      if (pending) begin
        wcnt++;
        if (alu_lat > 0 && wcnt == alu_lat) begin
          chk("alu_hold", {alu_a, alu_b, alu_op}, held);
          alu_done   = 1'b1;
          alu_result = res;
          pending    = 1'b0;
        end
      end
      if (stray_req != stray_ack) begin
        alu_done   = 1'b1;
        alu_result = 8'h77;
        stray_ack  = stray_req;
      end
      if (alu_start) begin
        pending = 1'b1;
        wcnt    = 0;
        res     = alu_fn(alu_a, alu_b, alu_op);
        held    = {alu_a, alu_b, alu_op};
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 32'(resp_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("resp_id", 32'(resp_id), e.id);
          chk("resp_result", 32'(resp_result), 32'(e.res));
          chk("resp_err", 32'(resp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic wait_idle();
    logic done_w;
    done_w = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (!busy) begin
        done_w = 1'b1;
        break;
      end
      step();
    end
    if (!done_w) chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    int resp_at;
    int exp_len;
    logic ended;
    req = '0;
    req[v.id] = 1'b1;
    req_a[v.id*DATA_W +: DATA_W] = v.a;
    req_b[v.id*DATA_W +: DATA_W] = v.b;
    req_op[v.id*3 +: 3] = v.op;
    alu_lat = v.lat;
    sb.push_back('{v.id, v.res, v.err});
    step();
    chk("vec_ack", 32'(ack), 32'(1) << v.id);
    chk("vec_start", 32'(alu_start), 1);
    chk("vec_busy", 32'(busy), 1);
    chk("vec_operands", {alu_a, alu_b, alu_op}, {v.a, v.b, v.op});
    req = '0;
    n = 1;
    resp_at = 0;
    ended = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      n++;
      if (resp_valid) resp_at = n;
    end
    exp_len = (v.lat == 0 || v.lat > TIMEOUT) ? TIMEOUT + 2 : v.lat + 2;
    chk("vec_ended", 32'(ended), 1);
    chk("vec_busy_len", n, exp_len);
    chk("vec_resp_cycle", resp_at, exp_len);
  endtask

  // Hold req=mask until n acks arrive; expected order in rr_ids, 4 cycles apart.
  task automatic rr_run(input logic [3:0] mask, input int n);
    int acks;
    int prev;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*DATA_W +: DATA_W] = 8'(i + 1);
      req_b[i*DATA_W +: DATA_W] = 8'd10;
      req_op[i*3 +: 3] = 3'd0;
    end
    for (int k = 0; k < n; k++) sb.push_back('{rr_ids[k], 8'(rr_ids[k] + 11), 1'b0});
    alu_lat = 1;
    req = mask;
    acks = 0;
    prev = 0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (ack != '0) begin
        chk("rr_ack", 32'(ack), 32'(1) << rr_ids[acks]);
        if (acks > 0) chk("rr_gap", c - prev, 4);
        prev = c;
        acks++;
        if (acks == n) begin
          req = '0;
          break;
        end
      end
    end
    chk("rr_count", acks, n);
    req = '0;
    wait_idle();
  endtask

  initial begin
    logic seen;
    checks    = 0;
    failures  = 0;
    alu_lat   = 1;
    stray_req = 0;
    rst       = 1'b1;
    req       = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;

    vt[0] = '{0, 8'd7,   8'd5,   3'd0, 1,       8'd12,  1'b0};
    vt[1] = '{1, 8'd20,  8'd50,  3'd1, 3,       8'hE2,  1'b0};
    vt[2] = '{2, 8'hF0,  8'h3C,  3'd2, 2,       8'h30,  1'b0};
    vt[3] = '{1, 8'hA0,  8'h05,  3'd3, 1,       8'hA5,  1'b0};
    vt[4] = '{0, 8'd12,  8'd11,  3'd4, 5,       8'h84,  1'b0};
    vt[5] = '{2, 8'd100, 8'd7,   3'd5, 4,       8'h0E,  1'b0};
    vt[6] = '{2, 8'd9,   8'd3,   3'd5, 0,       8'hFF,  1'b1};
    vt[7] = '{1, 8'h20,  8'h0A,  3'd0, TIMEOUT, 8'h2A,  1'b0};
    vt[8] = '{3, 8'd200, 8'd100, 3'd0, 1,       8'h2C,  1'b0};

    #12;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_ctrl", {alu_start, resp_valid, resp_err, busy}, 0);
    chk("rst_operands", {alu_a, alu_b, alu_op}, 0);
    chk("rst_resp", {resp_id, resp_result}, 0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) run_vec(vt[i]);

    // Stray done while idle must not produce anything.
    stray_req++;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      seen = seen | resp_valid | busy;
    end
    chk("stray_quiet", 32'(seen), 0);

    // last_grant is 3 here, so full contention starts at 0.
    rr_ids = '{0, 1, 2, 3, 0};
    rr_run(4'b1111, 5);

    // Make last_grant=2, then contention between 0 and 1 wraps to 0.
    run_vec('{2, 8'd3, 8'd4, 3'd0, 1, 8'd7, 1'b0});
    rr_ids = '{0, 1, 0, 0, 0};
    rr_run(4'b0011, 3);

    // Reset in the middle of WAIT drops the transaction.
    req_a[DATA_W +: DATA_W] = 8'h55;
    req_b[DATA_W +: DATA_W] = 8'h66;
    req_op[3 +: 3] = 3'd3;
    alu_lat = 0;
    req = 4'b0010;
    step();
    chk("midrst_ack", 32'(ack), 32'h2);
    req = '0;
    step();
    step();
    step();
    chk("midrst_busy", 32'(busy), 1);
    rst = 1'b1;
    #2;
    chk("midrst_ack0", 32'(ack), 0);
    chk("midrst_ctrl", {alu_start, resp_valid, resp_err, busy}, 0);
    chk("midrst_operands", {alu_a, alu_b, alu_op}, 0);
    chk("midrst_resp", {resp_id, resp_result}, 0);
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      seen = seen | resp_valid;
    end
    chk("midrst_no_resp", 32'(seen), 0);
    rr_ids = '{0, 3, 0, 0, 0};
    rr_run(4'b1001, 2);

    step();
    step();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
